// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking lane gate sequencer.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OPEN_ENTER = 2'd1,
        OPEN_EXIT  = 2'd2,
        CLOSE      = 2'd3
    } lane_state_t;

    typedef enum logic {
        ENTER = 1'b0,
        EXIT  = 1'b1
    } side_t;

    localparam int DEF_CAPACITY    = 3;
    localparam int DEF_OPEN_CYCLES = 8;

endpackage

// File: rtl/gate_timer.sv
// 8-bit loadable down-counter; expire flags the last running count (count == 1).
module gate_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       clear,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = (count == 8'd1);

endmodule

// File: rtl/parking_lane_sequencer.sv
// Shared entry/exit lane gate sequencer with occupancy tracking.
// Build option EXIT_PRIORITY_EN: exit always wins entry/exit ties instead of round-robin.
//
// state      | meaning
// IDLE       | gate closed, sampling eligible requests
// OPEN_ENTER | gate open for an entering car, waiting for pass or timeout
// OPEN_EXIT  | gate open for an exiting car, waiting for pass or timeout
// CLOSE      | gate closing, one cycle, then back to IDLE
module parking_lane_sequencer
    import parking_pkg::*;
#(
    parameter  int CAPACITY    = DEF_CAPACITY,
    parameter  int OPEN_CYCLES = DEF_OPEN_CYCLES,
    localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_req,
    input  logic             exit_req,
    input  logic             car_pass,
    output logic             gate_open,
    output logic             grant_enter,
    output logic             grant_exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);

    lane_state_t state, next_state;
    logic        enter_ok, exit_ok;
    logic        timer_load, timer_clear, expire;
    logic        occ_inc, occ_dec, timeout_next;

`ifdef EXIT_PRIORITY_EN
    localparam lane_state_t TIE_STATE = OPEN_EXIT;
`else
    side_t       rr_last;
    lane_state_t tie_state;
    assign tie_state = (rr_last == EXIT) ? OPEN_ENTER : OPEN_EXIT;
`endif

    assign full     = (occupancy == CNT_W'(CAPACITY));
    assign empty    = (occupancy == '0);
    assign enter_ok = enter_req && !full;
    assign exit_ok  = exit_req && !empty;

    gate_timer u_gate_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (8'(OPEN_CYCLES)),
        .clear    (timer_clear),
        .expire   (expire)
    );

    always_comb begin
        next_state   = state;
        timer_load   = 1'b0;
        occ_inc      = 1'b0;
        occ_dec      = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (enter_ok && exit_ok) begin
`ifdef EXIT_PRIORITY_EN
                    next_state = TIE_STATE;
`else
                    next_state = tie_state;
`endif
                end else if (enter_ok) begin
                    next_state = OPEN_ENTER;
                end else if (exit_ok) begin
                    next_state = OPEN_EXIT;
                end
                timer_load = (next_state != IDLE);
            end
            OPEN_ENTER: begin
                if (car_pass) begin
                    next_state = CLOSE;
                    occ_inc    = 1'b1;
                end else if (expire) begin
                    next_state   = CLOSE;
                    timeout_next = 1'b1;
                end
            end
            OPEN_EXIT: begin
                if (car_pass) begin
                    next_state = CLOSE;
                    occ_dec    = 1'b1;
                end else if (expire) begin
                    next_state   = CLOSE;
                    timeout_next = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        timer_clear = (next_state == CLOSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            grant_enter <= 1'b0;
            grant_exit  <= 1'b0;
            timeout_err <= 1'b0;
            occupancy   <= '0;
        end else begin
            state       <= next_state;
            gate_open   <= (next_state == OPEN_ENTER) || (next_state == OPEN_EXIT);
            grant_enter <= (next_state == OPEN_ENTER);
            grant_exit  <= (next_state == OPEN_EXIT);
            timeout_err <= timeout_next;
            // eligibility gating should make these unreachable
            assert (!(occ_inc && full)) else $error("occupancy overflow attempt");
            assert (!(occ_dec && empty)) else $error("occupancy underflow attempt");
            if (occ_inc) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (occ_dec) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

`ifndef EXIT_PRIORITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= EXIT;
        end else if (timer_load) begin
            rr_last <= (next_state == OPEN_ENTER) ? ENTER : EXIT;
        end
    end
`endif

endmodule
